// File: rtl/seg7_scan_2digit.sv
// Two-digit multiplexed seven-segment driver for a 0..31 counter value, with a per-frame snapshot.
// Optional build macro LEADING_ZERO_BLANK_EN darkens a zero tens digit.
module seg7_scan_2digit #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [4:0] Q,
    output logic [6:0] SEG,
    output logic [1:0] AN
);

    localparam int              DW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0]   DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [6:0]      SEG_BLANK = 7'h7F;

    logic [DW-1:0] div_q, div_d;
    logic          sel_q, sel_d;
    logic [4:0]    snap_q, snap_d;
    logic [6:0]    seg_q, seg_d;
    logic [1:0]    an_q, an_d;

    logic          wrap;
    logic [1:0]    tens;
    logic [3:0]    ones;

    function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
        logic [6:0] pat;
        case (digit)
            4'd0:    pat = 7'h40;
            4'd1:    pat = 7'h79;
            4'd2:    pat = 7'h24;
            4'd3:    pat = 7'h30;
            4'd4:    pat = 7'h19;
            4'd5:    pat = 7'h12;
            4'd6:    pat = 7'h02;
            4'd7:    pat = 7'h78;
            4'd8:    pat = 7'h00;
            4'd9:    pat = 7'h10;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

    // Range compare is cheaper than a divider; snap never exceeds 31.
    always_comb begin
        tens = 2'd0;
        ones = snap_q[3:0];
        if (snap_q >= 5'd30) begin
            tens = 2'd3;
            ones = 4'(snap_q - 5'd30);
        end else if (snap_q >= 5'd20) begin
            tens = 2'd2;
            ones = 4'(snap_q - 5'd20);
        end else if (snap_q >= 5'd10) begin
            tens = 2'd1;
            ones = 4'(snap_q - 5'd10);
        end
    end

    always_comb begin
        wrap   = (div_q == DIV_LAST);
        div_d  = wrap ? '0 : div_q + DW'(1);
        sel_d  = wrap ? ~sel_q : sel_q;
        // Capture only when leaving the tens slot, so a frame always shows one value.
        snap_d = (wrap && sel_q) ? Q : snap_q;

        if (sel_q) begin
            an_d  = 2'b01;
            seg_d = seg_pattern({2'b00, tens});
`ifdef LEADING_ZERO_BLANK_EN
            if (tens == 2'd0) begin
                seg_d = SEG_BLANK;
            end
`endif
        end else begin
            an_d  = 2'b10;
            seg_d = seg_pattern(ones);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            div_q  <= '0;
            sel_q  <= 1'b0;
            snap_q <= 5'd0;
            seg_q  <= SEG_BLANK;
            an_q   <= 2'b11;
        end else begin
            div_q  <= div_d;
            sel_q  <= sel_d;
            snap_q <= snap_d;
            seg_q  <= seg_d;
            an_q   <= an_d;
        end
    end

    assign SEG = seg_q;
    assign AN  = an_q;

endmodule

// File: tb/tb_seg7_scan_2digit.sv
// Scoreboard bench for seg7_scan_2digit with SCAN_DIV=4: expectations are queued per clock edge.
module tb_seg7_scan_2digit;

    localparam int SCAN_DIV = 4;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] TENS_ZERO = 7'h7F;
`else
    localparam logic [6:0] TENS_ZERO = 7'h40;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [4:0] Q   = 5'd17;
    logic [6:0] SEG;
    logic [1:0] AN;

    seg7_scan_2digit #(.SCAN_DIV(SCAN_DIV)) dut (
        .CLK(CLK),
        .RST(RST),
        .Q  (Q),
        .SEG(SEG),
        .AN (AN)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         cyc;
        logic [1:0] an;
        logic [6:0] seg;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   base = 0;
    bit   done = 1'b0;

    logic [6:0] pat_tab [10];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic expect_at(input int e, input logic [1:0] an, input logic [6:0] seg, input string name);
        exp_t x;
        x.cyc = base + e;
        x.an  = an;
        x.seg = seg;
        x.name = name;
        exp_q.push_back(x);
    endtask

    task automatic wait_edge(input int e);
        while (cyc < base + e) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Monitor: compare every queued expectation at the edge it names.
    always @(negedge CLK) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            exp_t x;
            x = exp_q.pop_front();
            n_cmp++;
            if (x.cyc < cyc) begin
                n_bad++;
                $display("FAIL %s: expectation for cycle %0d missed (now %0d)", x.name, x.cyc, cyc);
            end else if (AN !== x.an || SEG !== x.seg) begin
                n_bad++;
                $display("FAIL %s cyc=%0d: got AN=%b SEG=%h, want AN=%b SEG=%h",
                         x.name, cyc, AN, SEG, x.an, x.seg);
            end else begin
                $display("ok   %s cyc=%0d AN=%b SEG=%h", x.name, cyc, AN, SEG);
            end
        end
    end

    initial begin
        int s;
        pat_tab[0] = 7'h40; pat_tab[1] = 7'h79; pat_tab[2] = 7'h24; pat_tab[3] = 7'h30;
        pat_tab[4] = 7'h19; pat_tab[5] = 7'h12; pat_tab[6] = 7'h02; pat_tab[7] = 7'h78;
        pat_tab[8] = 7'h00; pat_tab[9] = 7'h10;

        // Reset held for three edges with Q=17.
        base = 0;
        expect_at(1, 2'b11, 7'h7F, "rst_e1");
        expect_at(2, 2'b11, 7'h7F, "rst_e2");
        expect_at(3, 2'b11, 7'h7F, "rst_e3");
        wait_edge(3);
        RST = 1'b0;
        Q   = 5'd23;
        base = 3;

        expect_at(1,  2'b10, 7'h40,     "post_rst_e1");
        expect_at(4,  2'b10, 7'h40,     "ones0_e4");
        expect_at(5,  2'b01, TENS_ZERO, "tens0_e5");
        expect_at(8,  2'b01, TENS_ZERO, "tens0_e8");
        expect_at(9,  2'b10, 7'h30,     "d23_ones_e9");
        expect_at(12, 2'b10, 7'h30,     "d23_ones_e12");
        expect_at(13, 2'b01, 7'h24,     "d23_tens_e13");
        expect_at(16, 2'b01, 7'h24,     "d23_tens_e16");
        expect_at(17, 2'b10, 7'h79,     "d31_ones_e17");
        expect_at(21, 2'b01, 7'h30,     "d31_tens_e21");

        // Tearing guard: change Q mid-frame.
        wait_edge(10);
        Q = 5'd31;

        // Sweep 0..31, one value per frame; snapshot at 32+8v.
        for (int v = 0; v < 32; v++) begin
            s = 24 + 8 * v;
            expect_at(s + 9,  2'b10, pat_tab[v % 10], $sformatf("sweep%0d_ones", v));
            expect_at(s + 13, 2'b01, (v < 10) ? TENS_ZERO : pat_tab[v / 10],
                      $sformatf("sweep%0d_tens", v));
            wait_edge(s);
            Q = 5'(v);
        end

        // Leading zero: Q=5 snapshotted at edge 288.
        wait_edge(280);
        Q = 5'd5;
        expect_at(289, 2'b10, 7'h12,     "lz_ones");
        expect_at(293, 2'b01, TENS_ZERO, "lz_tens");

        // Reset for one edge during the tens slot.
        wait_edge(293);
        RST = 1'b1;
        expect_at(294, 2'b11, 7'h7F, "midrst_blank");
        expect_at(295, 2'b10, 7'h40, "midrst_e1");
        expect_at(299, 2'b01, TENS_ZERO, "midrst_tens0");
        expect_at(302, 2'b01, TENS_ZERO, "midrst_e8");
        expect_at(303, 2'b10, 7'h12, "midrst_resnap");
        wait_edge(294);
        RST = 1'b0;

        wait_edge(310);
        done = 1'b1;
    end

    initial begin
        int limit;
        limit = 0;
        while (!done && limit < 5000) begin
            @(posedge CLK);
            limit++;
        end
        @(negedge CLK);
        #1;
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: stimulus not finished after %0d cycles", limit);
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL leftover: %0d expectations never checked, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
